expr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one fixed-latency `expr` floating-point pipeline between two requesters. It accepts IEEE-754 single-precision operands through valid/ready handshakes, issues at most one per cycle into `expr`, and tracks each in-flight operand with a tag shift register. Each result is returned to its originating requester, tagged, in issue order. It sits between the operand sources and the `expr` instance; `expr` itself is unchanged.

---
 rtl/expr_arbiter_if.sv | 38 +++
 rtl/expr_arbiter.sv | 82 ++++++++
 tb/tb_expr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/expr_arbiter_if.sv
// Requester, expr pipeline and response signals shared by
// expr_arbiter (slave side) and its environment (master side).
interface expr_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_x;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_x;
  logic        req1_ready;
  logic [31:0] expr_x;
  logic [31:0] expr_result;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [7:0]  out0_cnt;
  logic [7:0]  out1_cnt;
  logic        busy;

  modport slave (
    input  req0_valid, req0_x,
    input  req1_valid, req1_x,
    input  expr_result,
    output req0_ready, req1_ready,
    output expr_x,
    output rsp_valid, rsp_id, rsp_result,
    output out0_cnt, out1_cnt, busy
  );

  modport master (
    output req0_valid, req0_x,
    output req1_valid, req1_x,
    output expr_result,
    input  req0_ready, req1_ready,
    input  expr_x,
    input  rsp_valid, rsp_id, rsp_result,
    input  out0_cnt, out1_cnt, busy
  );
endinterface

// File: rtl/expr_arbiter.sv
// Round-robin sharing of one fixed-latency expr pipeline by two
// requesters; a tag shift register routes results back in order.
module expr_arbiter #(
  parameter int LATENCY = 16,
  parameter int MAX_OUT = 8
) (
  input logic           clk,
  input logic           reset,
  expr_arbiter_if.slave bus
);
  localparam logic [7:0] MAX_C = 8'(MAX_OUT);

  logic             r_last;
  logic [7:0]       r_cnt0;
  logic [7:0]       r_cnt1;
  logic [31:0]      r_x;
  logic [LATENCY:0] r_tv;
  logic [LATENCY:0] r_tid;

  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_issue;
  logic w_rv;
  logic w_rid;

  function automatic logic [7:0] upd(
    input logic [7:0] cnt,
    input logic       inc,
    input logic       dec
  );
    logic [7:0] n;
    n = cnt;
    unique case ({inc, dec})
      2'b10:   n = cnt + 8'd1;
      2'b01:   n = cnt - 8'd1;
      default: n = cnt;
    endcase
    return n;
  endfunction

  // Eligibility uses registered counts, never the returning tag.
  assign w_elig0 = bus.req0_valid && (r_cnt0 < MAX_C) && !reset;
  assign w_elig1 = bus.req1_valid && (r_cnt1 < MAX_C) && !reset;

  assign w_gnt0  = w_elig0 && (!w_elig1 || r_last);
  assign w_gnt1  = w_elig1 && (!w_elig0 || !r_last);
  assign w_issue = w_gnt0 || w_gnt1;

  assign w_rv  = r_tv[LATENCY];
  assign w_rid = r_tid[LATENCY];

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.expr_x     = r_x;
  assign bus.rsp_valid  = w_rv;
  assign bus.rsp_id     = w_rid;
  assign bus.rsp_result = w_rv ? bus.expr_result : 32'h0;
  assign bus.out0_cnt   = r_cnt0;
  assign bus.out1_cnt   = r_cnt1;
  assign bus.busy       = (r_cnt0 != 8'd0) || (r_cnt1 != 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
      r_x    <= 32'h0;
      r_tv   <= '0;
      r_tid  <= '0;
      r_cnt0 <= 8'd0;
      r_cnt1 <= 8'd0;
    end else begin
      if (w_issue) r_last <= w_gnt1;
      r_x <= w_gnt0 ? bus.req0_x :
             w_gnt1 ? bus.req1_x : 32'h0;
      r_tv   <= {r_tv[LATENCY-1:0], w_issue};
      r_tid  <= {r_tid[LATENCY-1:0], w_gnt1};
      r_cnt0 <= upd(r_cnt0, w_gnt0, w_rv && !w_rid);
      r_cnt1 <= upd(r_cnt1, w_gnt1, w_rv && w_rid);
    end
  end
endmodule

// File: tb/tb_expr_arbiter.sv
// Bench for expr_arbiter: two instances (MAX_OUT 8 and 2), each
// with a behavioural expr pipeline and an in-order scoreboard.
module tb_expr_arbiter;
  localparam int LAT = 16;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q [2][$];

  logic [31:0] pa [LAT];
  logic [31:0] pb [LAT];

  expr_arbiter_if ia ();
  expr_arbiter_if ib ();

  expr_arbiter #(.LATENCY(LAT), .MAX_OUT(8)) u_a (
    .clk(clk), .reset(reset), .bus(ia)
  );
  expr_arbiter #(.LATENCY(LAT), .MAX_OUT(2)) u_b (
    .clk(clk), .reset(reset), .bus(ib)
  );

  function automatic logic [31:0] fx(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5a5a0f0f;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
    pa[0] <= ia.expr_x;
    pb[0] <= ib.expr_x;
  end
  assign ia.expr_result = fx(pa[LAT-1]);
  assign ib.expr_result = fx(pb[LAT-1]);

  task automatic mon(
    input int w, input logic rv, input logic rid,
    input logic [31:0] rr,
    input logic v0, input logic r0, input logic [31:0] x0,
    input logic v1, input logic r1, input logic [31:0] x1
  );
    exp_t e;
    if (reset) begin
      q[w].delete();
    end else begin
      checks++;
      if (r0 && r1) begin
        errors++;
        $display("FAIL dual_ready dut%0d got both ready", w);
      end
      checks++;
      if (rv === 1'b1) begin
        if (q[w].size() == 0) begin
          errors++;
          $display("FAIL rsp_extra dut%0d got id=%0d res=%h want none",
                   w, rid, rr);
        end else begin
          e = q[w].pop_front();
          if (rid !== e.id || rr !== e.res || cyc != e.cyc) begin
            errors++;
            $display("FAIL rsp dut%0d got id=%0d res=%h cyc=%0d want id=%0d res=%h cyc=%0d",
                     w, rid, rr, cyc, e.id, e.res, e.cyc);
          end
        end
      end else if (rv !== 1'b0 || rr !== 32'h0) begin
        errors++;
        $display("FAIL rsp_idle dut%0d got v=%b res=%h want v=0 res=0",
                 w, rv, rr);
      end
      if (v0 && r0) begin
        e.id = 1'b0; e.res = fx(x0); e.cyc = cyc + 1 + LAT;
        q[w].push_back(e);
      end
      if (v1 && r1) begin
        e.id = 1'b1; e.res = fx(x1); e.cyc = cyc + 1 + LAT;
        q[w].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ia.rsp_valid, ia.rsp_id, ia.rsp_result,
        ia.req0_valid, ia.req0_ready, ia.req0_x,
        ia.req1_valid, ia.req1_ready, ia.req1_x);
    mon(1, ib.rsp_valid, ib.rsp_id, ib.rsp_result,
        ib.req0_valid, ib.req0_ready, ib.req0_x,
        ib.req1_valid, ib.req1_ready, ib.req1_x);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ia.req0_valid = 0; ia.req1_valid = 0;
    ib.req0_valid = 0; ib.req1_valid = 0;
    ia.req0_x = 0; ia.req1_x = 0;
    ib.req0_x = 0; ib.req1_x = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (ia.busy || ib.busy); i++) tick();
    checks++;
    if (ia.busy || ib.busy || q[0].size() != 0 || q[1].size() != 0) begin
      errors++;
      $display("FAIL drain got busy=%b%b pend=%0d/%0d want idle",
               ia.busy, ib.busy, q[0].size(), q[1].size());
    end
  endtask

  task automatic test_reset();
    reset = 1;
    ia.req0_valid = 1; ia.req1_valid = 1;
    ib.req0_valid = 1; ib.req1_valid = 1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({ia.req0_ready, ia.req1_ready, ib.req0_ready, ib.req1_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ready got %b%b%b%b want 0000", ia.req0_ready,
               ia.req1_ready, ib.req0_ready, ib.req1_ready);
    end
    checks++;
    if (ia.rsp_valid !== 0 || ia.rsp_id !== 0 || ia.rsp_result !== 0 ||
        ia.busy !== 0 || ia.expr_x !== 0 || ia.out0_cnt !== 0 ||
        ia.out1_cnt !== 0) begin
      errors++;
      $display("FAIL reset_state got v=%b id=%b res=%h busy=%b x=%h cnt=%0d/%0d want zeros",
               ia.rsp_valid, ia.rsp_id, ia.rsp_result, ia.busy,
               ia.expr_x, ia.out0_cnt, ia.out1_cnt);
    end
    tick();
    idle_all();
    reset = 0;
  endtask

  task automatic test_single();
    ia.req0_valid = 1; ia.req0_x = 32'h3f000000;
    @(negedge clk);
    checks++;
    if (ia.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b want 1", ia.req0_ready);
    end
    tick();
    ia.req0_valid = 0;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      checks++;
      if (ia.busy !== 1'b1 || ia.rsp_valid !== (i == LAT)) begin
        errors++;
        $display("FAIL single_cyc%0d got busy=%b v=%b want busy=1 v=%b",
                 i, ia.busy, ia.rsp_valid, (i == LAT));
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (ia.busy !== 1'b0 || ia.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_end got busy=%b v=%b want 0 0",
               ia.busy, ia.rsp_valid);
    end
    tick();
  endtask

  task automatic test_contention();
    logic e0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ia.req0_valid = 1; ia.req0_x = 32'h40000000 + i;
      ia.req1_valid = 1; ia.req1_x = 32'hc0000000 + i;
      e0 = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (ia.req0_ready !== e0 || ia.req1_ready !== !e0) begin
        errors++;
        $display("FAIL contend_%0d got r0=%b r1=%b want r0=%b r1=%b",
                 i, ia.req0_ready, ia.req1_ready, e0, !e0);
      end
      tick();
    end
    idle_all();
    drain();
  endtask

  task automatic test_bubbles();
    int seen [$];
    for (int i = 0; i < 30; i++) begin
      ia.req1_valid = (i == 0 || i == 4);
      ia.req1_x = 32'h41200000 + i;
      @(negedge clk);
      if (ia.rsp_valid) seen.push_back(i);
      tick();
    end
    idle_all();
    checks++;
    if (seen.size() != 2) begin
      errors++;
      $display("FAIL bubble_count got %0d want 2", seen.size());
    end else begin
      checks++;
      if (seen[0] != LAT + 1 || seen[1] != LAT + 5) begin
        errors++;
        $display("FAIL bubble_gap got %0d,%0d want %0d,%0d",
                 seen[0], seen[1], LAT + 1, LAT + 5);
      end
    end
    drain();
  endtask

  task automatic test_credit();
    logic e0;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      ib.req0_valid = 1; ib.req0_x = 32'h3f800000 + i;
      e0 = (i < 2) || (i == LAT + 2) || (i == LAT + 3);
      @(negedge clk);
      checks++;
      if (ib.req0_ready !== e0 || ib.out0_cnt > 8'd2) begin
        errors++;
        $display("FAIL credit_%0d got r0=%b cnt=%0d want r0=%b cnt<=2",
                 i, ib.req0_ready, ib.out0_cnt, e0);
      end
      tick();
    end
    idle_all();
    drain();
  endtask

  task automatic test_starvation();
    logic e0;
    logic e1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ib.req0_valid = 1; ib.req0_x = 32'h3e000000 + i;
      ib.req1_valid = (i >= 2); ib.req1_x = 32'hbe000000 + i;
      e0 = (i < 2);
      e1 = (i == 2 || i == 3);
      @(negedge clk);
      checks++;
      if (ib.req0_ready !== e0 || ib.req1_ready !== e1) begin
        errors++;
        $display("FAIL starve_%0d got r0=%b r1=%b want r0=%b r1=%b",
                 i, ib.req0_ready, ib.req1_ready, e0, e1);
      end
      tick();
    end
    idle_all();
    drain();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      ia.req0_valid = 1; ia.req0_x = 32'h42000000 + i;
      tick();
    end
    idle_all();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      checks++;
      if (ia.rsp_valid !== 0 || ia.out0_cnt !== 0 || ia.busy !== 0) begin
        errors++;
        $display("FAIL midrst_%0d got v=%b cnt=%0d busy=%b want 0 0 0",
                 i, ia.rsp_valid, ia.out0_cnt, ia.busy);
      end
      tick();
    end
    ia.req0_valid = 1; ia.req0_x = 32'h40490fdb;
    ia.req1_valid = 1; ia.req1_x = 32'hc0490fdb;
    @(negedge clk);
    checks++;
    if (ia.req0_ready !== 1'b1 || ia.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_tie got r0=%b r1=%b want r0=1 r1=0",
               ia.req0_ready, ia.req1_ready);
    end
    tick();
    idle_all();
    drain();
  endtask

  initial begin
    idle_all();
    reset = 1;
    test_reset();
    test_single();
    test_contention();
    test_bubbles();
    test_credit();
    test_starvation();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
